// File: rtl/acc_pkg.sv
// Shared constants for the accelerometer frame packer: sync byte, FSM encoding,
// FIFO entry layout {seq, ts, X, Y, Z} and the frame word selector.
package acc_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_WORDS       = 5;
    localparam int         ENTRY_W           = 72;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_W0   = 3'd1;
    localparam logic [2:0] ST_W1   = 3'd2;
    localparam logic [2:0] ST_W2   = 3'd3;
    localparam logic [2:0] ST_W3   = 3'd4;
    localparam logic [2:0] ST_W4   = 3'd5;

    localparam int SEQ_LSB = 64;
    localparam int TS_LSB  = 48;
    localparam int X_LSB   = 32;
    localparam int Y_LSB   = 16;
    localparam int Z_LSB   = 0;

    // Word idx of a frame built from one buffered entry (0 = header).
    function automatic logic [15:0] frame_word(input logic [2:0]         idx,
                                               input logic [ENTRY_W-1:0] entry,
                                               input logic [7:0]         sync);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {sync, entry[SEQ_LSB +: 8]};
            3'd1:    w = entry[TS_LSB +: 16];
            3'd2:    w = entry[X_LSB +: 16];
            3'd3:    w = entry[Y_LSB +: 16];
            default: w = entry[Z_LSB +: 16];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/acc_sample_fifo.sv
// First-word-fall-through synchronous FIFO holding timestamped samples.
// rdata_next exposes the entry behind the head so a new frame can start the cycle the head pops.
module acc_sample_fifo
    import acc_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic                     pclk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign rdata      = mem[rd_ptr];
    assign rdata_next = mem[rd_ptr_nxt];
    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign level      = count;

endmodule

// File: rtl/acc_frame_packer.sv
// Captures accelerometer samples (decimated, timestamped, sequenced), buffers them and
// streams each one as a 5-word frame; drops on a full buffer are counted, never stalled.
module acc_frame_packer
    import acc_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                   pclk,
    input  logic                   rstb,
    input  logic [47:0]            acc_data,
    input  logic                   acc_valid,
    input  logic                   enable,
    input  logic [7:0]             decim,
    input  logic                   clr_ovf,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int         LW       = $clog2(DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_WORDS - 1);

    logic [15:0]        ts;
    logic [7:0]         dc;
    logic [7:0]         dc_eff;
    logic [7:0]         seq;
    logic               keep;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic               more_buffered;
    logic               next_avail;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
    logic [ENTRY_W-1:0] rdata_next;
    logic [ENTRY_W-1:0] next_head;
    logic [2:0]         state;

    // A shrunken decim restarts the decimation phase at once instead of waiting for a wrap.
    assign dc_eff        = (dc > decim) ? 8'd0 : dc;
    assign keep          = acc_valid & enable & (dc_eff == 8'd0);
    assign pop           = (state == ST_W4) & out_ready;
    assign push          = keep & (~full | pop);
    assign drop          = keep & full & ~pop;
    assign wdata         = {seq, ts, acc_data};
    assign more_buffered = (level > LW'(1));
    assign next_avail    = more_buffered | push;
    assign next_head     = more_buffered ? rdata_next : wdata;

    acc_sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .pclk       (pclk),
        .rstb       (rstb),
        .push       (push),
        .wdata      (wdata),
        .pop        (pop),
        .rdata      (rdata),
        .rdata_next (rdata_next),
        .full       (full),
        .empty      (empty),
        .level      (level)
    );

    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            ts  <= 16'd0;
            dc  <= 8'd0;
            seq <= 8'd0;
        end else begin
            if (acc_valid) begin
                ts <= ts + 16'd1;
            end
            if (!enable) begin
                dc <= 8'd0;
            end else if (acc_valid) begin
                dc <= (dc_eff == decim) ? 8'd0 : dc_eff + 8'd1;
            end else begin
                dc <= dc_eff;
            end
            if (push) begin
                seq <= seq + 8'd1;
            end
        end
    end

    // A drop coinciding with clr_ovf restarts the count at one rather than zero.
    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clr_ovf ? 8'd1 :
                          (drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    // Encoding Wk = k+1, so from state Wk the next word index equals the state value.
    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state     <= ST_W0;
                        out_data  <= frame_word(3'd0, rdata, SYNC_BYTE);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                ST_W0, ST_W1, ST_W2, ST_W3: begin
                    if (out_ready) begin
                        state    <= state + 3'd1;
                        out_data <= frame_word(state, rdata, SYNC_BYTE);
                        out_last <= (state == LAST_IDX);
                    end
                end
                ST_W4: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        if (next_avail) begin
                            state    <= ST_W0;
                            out_data <= frame_word(3'd0, next_head, SYNC_BYTE);
                        end else begin
                            state     <= ST_IDLE;
                            out_data  <= 16'd0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_data  <= 16'd0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_frame_packer.sv
// Scoreboard bench for acc_frame_packer: a queue-based sample/frame model predicts every
// word, level and drop statistic; a negedge monitor compares whenever a word is handed over.
module tb_acc_frame_packer;

    localparam int DEPTH = 8;

    logic        pclk      = 1'b0;
    logic        rstb      = 1'b0;
    logic [47:0] acc_data  = '0;
    logic        acc_valid = 1'b0;
    logic        enable    = 1'b0;
    logic [7:0]  decim     = '0;
    logic        clr_ovf   = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    acc_frame_packer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .pclk       (pclk),
        .rstb       (rstb),
        .acc_data   (acc_data),
        .acc_valid  (acc_valid),
        .enable     (enable),
        .decim      (decim),
        .clr_ovf    (clr_ovf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #25 pclk = ~pclk;

    logic [16:0] exp_q [$];
    int          m_level;
    logic        m_overflow;
    int          m_drops;
    logic [15:0] m_ts;
    logic [7:0]  m_seq;
    int          m_phase;
    logic [7:0]  m_last_decim;
    logic        stalled_prev;
    logic [15:0] held_data;
    logic        pop_now;
    logic        keep_s;
    logic        dropped;
    logic [16:0] e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_words  = 0;
    int          n_frames = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    task automatic modelPush(input logic [47:0] d);
        exp_q.push_back({1'b0, 8'hA5, m_seq});
        exp_q.push_back({1'b0, m_ts});
        exp_q.push_back({1'b0, d[47:32]});
        exp_q.push_back({1'b0, d[31:16]});
        exp_q.push_back({1'b1, d[15:0]});
        m_seq++;
        m_level++;
    endtask

    // Monitor + reference model: looks at what the coming edge will see and predicts its effect.
    always @(negedge pclk) begin
        if (!rstb) begin
            exp_q.delete();
            m_level      = 0;
            m_overflow   = 1'b0;
            m_drops      = 0;
            m_ts         = '0;
            m_seq        = '0;
            m_phase      = 0;
            m_last_decim = decim;
            stalled_prev = 1'b0;
        end else begin
            checkOutput("level", 32'(level), m_level);
            checkOutput("overflow", 32'(overflow), 32'(m_overflow));
            checkOutput("drop_count", 32'(drop_count), m_drops);
            if (stalled_prev) begin
                checkOutput("hold_valid", 32'(out_valid), 1);
                checkOutput("hold_data", 32'(out_data), 32'(held_data));
            end
            stalled_prev = out_valid && !out_ready;
            held_data    = out_data;

            pop_now = 1'b0;
            if (out_valid && out_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 32'(out_data), 32'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("word", 32'(out_data), 32'(e[15:0]));
                    checkOutput("last", 32'(out_last), 32'(e[16]));
                    pop_now = e[16];
                    if (e[16]) n_frames++;
                end
            end

            if (decim != m_last_decim) begin
                m_phase      = 0;
                m_last_decim = decim;
            end
            dropped = 1'b0;
            if (acc_valid) begin
                keep_s = 1'b0;
                if (enable) begin
                    keep_s = ((m_phase % (int'(decim) + 1)) == 0);
                    m_phase++;
                end
                if (keep_s) begin
                    if (m_level == DEPTH && !pop_now) begin
                        dropped    = 1'b1;
                        m_overflow = 1'b1;
                        m_drops    = clr_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
                    end else begin
                        modelPush(acc_data);
                    end
                end
                m_ts++;
            end
            if (!enable) m_phase = 0;
            if (pop_now) m_level--;
            if (clr_ovf && !dropped) begin
                m_overflow = 1'b0;
                m_drops    = 0;
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic applyStimulus(input logic v, input logic [47:0] d, input logic clr);
        acc_valid = v;
        acc_data  = d;
        clr_ovf   = clr;
        @(posedge pclk); #1;
        acc_valid = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && k < limit) begin
            @(posedge pclk); #1;
            k++;
        end
        checkOutput("drain_done", 32'(exp_q.size() == 0 && !out_valid), 1);
    endtask

    task automatic doReset();
        rstb      = 1'b0;
        acc_valid = 1'b0;
        clr_ovf   = 1'b0;
        idleCycles(2);
        rstb = 1'b1;
    endtask

    initial begin
        #(50 * 60000);
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_words;
        int start_frames;
        logic gap;
        logic found;

        idleCycles(1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_last", 32'(out_last), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_drop_count", 32'(drop_count), 0);
        idleCycles(1);
        rstb = 1'b1;

        $display("[TB] single sample latency and framing");
        enable    = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 48'h1111_2222_3333, 1'b0);
        checkOutput("t1_valid_early", 32'(out_valid), 0);
        idleCycles(1);
        checkOutput("t1_first_valid", 32'(out_valid), 1);
        checkOutput("t1_first_word", 32'(out_data), 32'h0000_A500);
        drain(50);

        $display("[TB] decimation by 3");
        doReset();
        decim        = 8'd2;
        start_frames = n_frames;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, rand48(), 1'b0);
        drain(100);
        checkOutput("t2_frames", n_frames - start_frames, 3);

        $display("[TB] fill, overflow and saturation");
        doReset();
        decim     = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, rand48(), 1'b0);
        idleCycles(1);
        checkOutput("t3_level", 32'(level), 8);
        checkOutput("t3_overflow", 32'(overflow), 1);
        checkOutput("t3_drop_count", 32'(drop_count), 2);
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, rand48(), 1'b0);
        checkOutput("t3_drop_sat", 32'(drop_count), 255);
        start_frames = n_frames;
        drain(200);
        checkOutput("t3_frames", n_frames - start_frames, 8);

        $display("[TB] toggling ready, back-to-back frames");
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, rand48(), 1'b0);
        applyStimulus(1'b1, rand48(), 1'b0);
        idleCycles(2);
        start_words = n_words;
        gap = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (n_words - start_words >= 10) break;
            if (!out_valid) gap = 1'b1;
            out_ready = ~out_ready;
            @(posedge pclk); #1;
        end
        checkOutput("t4_no_idle", 32'(gap), 0);
        checkOutput("t4_words", n_words - start_words, 10);
        drain(50);

        $display("[TB] push on full during pop, clear racing a drop");
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, rand48(), 1'b0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_valid && out_last) begin
                acc_valid = 1'b1;
                acc_data  = rand48();
                @(posedge pclk); #1;
                acc_valid = 1'b0;
                out_ready = 1'b0;
                found     = 1'b1;
            end else begin
                @(posedge pclk); #1;
            end
        end
        checkOutput("t5_w4_seen", 32'(found), 1);
        checkOutput("t5_level", 32'(level), 8);
        checkOutput("t5_no_drop", 32'(drop_count), 2);
        applyStimulus(1'b1, rand48(), 1'b1);
        checkOutput("t5_clr_drop_count", 32'(drop_count), 1);
        checkOutput("t5_clr_overflow", 32'(overflow), 1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t5_cleared", 32'({overflow, drop_count}), 0);
        drain(200);

        $display("[TB] reset mid-frame");
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 48'hAAAA_BBBB_CCCC, 1'b0);
        idleCycles(1);
        out_ready = 1'b1;
        idleCycles(2);
        out_ready = 1'b0;
        checkOutput("t6_in_w2", 32'(out_data), 32'h0000_AAAA);
        rstb = 1'b0;
        #1;
        checkOutput("t6_rst_outputs", 32'({out_valid, out_last, out_data, level, overflow, drop_count}), 0);
        idleCycles(2);
        rstb      = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 48'h0123_4567_89AB, 1'b0);
        idleCycles(1);
        checkOutput("t6_seq0", 32'(out_data), 32'h0000_A500);
        drain(50);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if (!enable && $urandom_range(0, 1) == 1) decim = 8'($urandom_range(0, 3));
            acc_valid = ($urandom_range(0, 2) == 0);
            acc_data  = rand48();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 30) == 0);
            @(posedge pclk); #1;
        end
        acc_valid = 1'b0;
        clr_ovf   = 1'b0;
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
